player_move: RTL and testbench

PLAYER_MOVE -- requirements
Module: player_move

---
 rtl/player_move.sv | 168 ++++++++++++++++
 tb/tb_player_move.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/player_move.sv
// rtl/player_move.sv - per-frame player position and jump/fall state machine.
// Optional JUMP_BUFFER_EN remembers a jump press for up to four frames before landing.
module player_move #(
    parameter int X_INIT   = 512,
    parameter int Y_INIT   = 100,
    parameter int H_STEP   = 4,
    parameter int JUMP_VEL = 16,
    parameter int GRAVITY  = 1,
    parameter int MAX_FALL = 12,
    parameter int X_MIN    = 32,
    parameter int X_MAX    = 992,
    parameter int Y_MAX    = 736
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        key_left,
    input  logic        key_right,
    input  logic        key_jump,
    input  logic        collision_up,
    input  logic        collision_down,
    input  logic        collision_left,
    input  logic        collision_right,
    output logic [10:0] xpos,
    output logic [10:0] ypos,
    output logic        on_ground
);

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        JUMP   = 2'd1,
        FALL   = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [5:0]  vy, vy_nxt;
    logic [10:0] x_nxt, y_nxt;
    logic [11:0] x_ext;
    logic [5:0]  vy_up;
    logic [6:0]  vy_dn_raw;
    logic [5:0]  vy_dn;
    logic [11:0] y_dn;
    logic        jump_want;
    logic        jump_taken;

    // Upward moves stop at the top of the screen instead of wrapping.
    function automatic logic [10:0] sub_sat0(input logic [10:0] y, input logic [5:0] d);
        logic [11:0] diff;
        diff = {1'b0, y} - {6'd0, d};
        sub_sat0 = diff[11] ? 11'd0 : diff[10:0];
    endfunction

`ifdef JUMP_BUFFER_EN
    logic       key_jump_d;
    logic       jump_req;
    logic [1:0] req_age;
    logic       key_rise;

    assign key_rise  = key_jump & ~key_jump_d;
    assign jump_want = jump_req | key_jump;

    // A fresh press wins over an expiry or acceptance on the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_jump_d <= 1'b0;
            jump_req   <= 1'b0;
            req_age    <= 2'd0;
        end else begin
            key_jump_d <= key_jump;
            if (key_rise) begin
                jump_req <= 1'b1;
                req_age  <= 2'd0;
            end else if (frame_tick && jump_req) begin
                if (jump_taken || req_age == 2'd3) begin
                    jump_req <= 1'b0;
                    req_age  <= 2'd0;
                end else begin
                    req_age <= req_age + 2'd1;
                end
            end
        end
    end
`else
    assign jump_want = key_jump;
`endif

    assign jump_taken = (state == GROUND) && collision_down && jump_want;

    always_comb begin
        x_nxt = xpos;
        x_ext = {1'b0, xpos};
        if (key_right && !key_left && !collision_right) begin
            if (x_ext + 12'(H_STEP) >= 12'(X_MAX)) begin
                x_nxt = 11'(X_MAX);
            end else begin
                x_nxt = xpos + 11'(H_STEP);
            end
        end else if (key_left && !key_right && !collision_left) begin
            if (x_ext <= 12'(X_MIN + H_STEP)) begin
                x_nxt = 11'(X_MIN);
            end else begin
                x_nxt = xpos - 11'(H_STEP);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        vy_nxt    = vy;
        y_nxt     = ypos;
        vy_up     = vy - 6'(GRAVITY);
        vy_dn_raw = {1'b0, vy} + 7'(GRAVITY);
        vy_dn     = (vy_dn_raw > 7'(MAX_FALL)) ? 6'(MAX_FALL) : vy_dn_raw[5:0];
        y_dn      = {1'b0, ypos} + {6'd0, vy_dn};
        unique case (state)
            GROUND: begin
                if (!collision_down) begin
                    state_nxt = FALL;
                    vy_nxt    = 6'd0;
                end else if (jump_taken) begin
                    state_nxt = JUMP;
                    vy_nxt    = 6'(JUMP_VEL);
                    y_nxt     = sub_sat0(ypos, 6'(JUMP_VEL));
                end
            end
            JUMP: begin
                if (collision_up || vy <= 6'(GRAVITY)) begin
                    state_nxt = FALL;
                    vy_nxt    = 6'd0;
                end else begin
                    vy_nxt = vy_up;
                    y_nxt  = sub_sat0(ypos, vy_up);
                end
            end
            default: begin
                if (collision_down) begin
                    state_nxt = GROUND;
                    vy_nxt    = 6'd0;
                end else if (y_dn >= 12'(Y_MAX)) begin
                    state_nxt = GROUND;
                    vy_nxt    = 6'd0;
                    y_nxt     = 11'(Y_MAX);
                end else begin
                    state_nxt = FALL;
                    vy_nxt    = vy_dn;
                    y_nxt     = y_dn[10:0];
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FALL;
            vy    <= 6'd0;
            xpos  <= 11'(X_INIT);
            ypos  <= 11'(Y_INIT);
        end else if (frame_tick) begin
            state <= state_nxt;
            vy    <= vy_nxt;
            xpos  <= x_nxt;
            ypos  <= y_nxt;
        end
    end

    assign on_ground = (state == GROUND);

endmodule

// File: tb/tb_player_move.sv
// tb/tb_player_move.sv - directed and random checks of player_move against a frame-level model.
module tb_player_move;

    localparam int P_GROUND = 0;
    localparam int P_JUMP   = 1;
    localparam int P_FALL   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_tick = 1'b0;
    logic        key_left = 1'b0, key_right = 1'b0, key_jump = 1'b0;
    logic        collision_up = 1'b0, collision_down = 1'b0;
    logic        collision_left = 1'b0, collision_right = 1'b0;
    logic [10:0] xpos, ypos;
    logic        on_ground;

    int n_cmp  = 0;
    int n_fail = 0;

    int m_x, m_y, m_vy, m_st, m_age;
    bit m_req, m_kprev;

    player_move dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .key_left(key_left), .key_right(key_right), .key_jump(key_jump),
        .collision_up(collision_up), .collision_down(collision_down),
        .collision_left(collision_left), .collision_right(collision_right),
        .xpos(xpos), .ypos(ypos), .on_ground(on_ground)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_edge(input bit rs, input bit ft, input bit l, input bit r, input bit j,
                              input bit cu, input bit cd, input bit cl, input bit cr);
        bit rise, want, taken;
        if (rs) begin
            m_x = 512; m_y = 100; m_vy = 0; m_st = P_FALL;
            m_req = 0; m_age = 0; m_kprev = 0;
            return;
        end
        rise    = j && !m_kprev;
        m_kprev = j;
        if (ft) begin
            if (r && !l && !cr)      m_x = (m_x + 4 > 992) ? 992 : m_x + 4;
            else if (l && !r && !cl) m_x = (m_x - 4 < 32) ? 32 : m_x - 4;
`ifdef JUMP_BUFFER_EN
            want = j || m_req;
`else
            want = j;
`endif
            taken = 0;
            if (m_st == P_GROUND) begin
                if (!cd) begin
                    m_st = P_FALL; m_vy = 0;
                end else if (want) begin
                    taken = 1; m_st = P_JUMP; m_vy = 16;
                    m_y = (m_y < 16) ? 0 : m_y - 16;
                end
            end else if (m_st == P_JUMP) begin
                if (cu || m_vy <= 1) begin
                    m_st = P_FALL; m_vy = 0;
                end else begin
                    m_vy = m_vy - 1;
                    m_y = (m_y < m_vy) ? 0 : m_y - m_vy;
                end
            end else begin
                if (cd) begin
                    m_st = P_GROUND; m_vy = 0;
                end else begin
                    m_vy = (m_vy + 1 > 12) ? 12 : m_vy + 1;
                    if (m_y + m_vy >= 736) begin
                        m_y = 736; m_st = P_GROUND; m_vy = 0;
                    end else begin
                        m_y = m_y + m_vy;
                    end
                end
            end
            if (m_req) begin
                if (taken) m_req = 0;
                else begin
                    m_age++;
                    if (m_age >= 4) m_req = 0;
                end
            end
        end
        if (rise) begin
            m_req = 1; m_age = 0;
        end
    endtask

    task automatic cycle(input bit rs, input bit ft, input bit l, input bit r, input bit j,
                         input bit cu, input bit cd, input bit cl, input bit cr);
        @(negedge clk);
        rst = rs; frame_tick = ft; key_left = l; key_right = r; key_jump = j;
        collision_up = cu; collision_down = cd; collision_left = cl; collision_right = cr;
        @(posedge clk);
        model_edge(rs, ft, l, r, j, cu, cd, cl, cr);
        #1;
        chk("xpos", 32'(xpos), 32'(m_x));
        chk("ypos", 32'(ypos), 32'(m_y));
        chk("on_ground", 32'(on_ground), 32'(m_st == P_GROUND));
    endtask

    task automatic tick(input bit l, input bit r, input bit j, input bit cu, input bit cd,
                        input bit cl, input bit cr);
        cycle(0, 1, l, r, j, cu, cd, cl, cr);
        cycle(0, 0, l, r, j, cu, cd, cl, cr);
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 1, 1, 1, 1, 1, 1, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int fall_exp[5];
        int y0;
        fall_exp = '{101, 103, 106, 110, 115};

        do_reset();
        chk("rst_x", 32'(xpos), 32'd512);
        chk("rst_y", 32'(ypos), 32'd100);
        chk("rst_ground", 32'(on_ground), 32'd0);

        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 0, 0, 0, 0, 0);
            chk("free_fall_y", 32'(ypos), 32'(fall_exp[i]));
            chk("free_fall_x", 32'(xpos), 32'd512);
        end

        for (int i = 0; i < 7; i++) tick(0, 0, 0, 0, 0, 0, 0);
        chk("fall_vy12_y", 32'(ypos), 32'd178);
        tick(0, 0, 0, 0, 1, 0, 0);
        chk("land_y_held", 32'(ypos), 32'd178);
        chk("land_ground", 32'(on_ground), 32'd1);

        tick(0, 0, 1, 0, 1, 0, 0);
        chk("jump_y0", 32'(ypos), 32'd162);
        chk("jump_air", 32'(on_ground), 32'd0);
        tick(0, 0, 0, 0, 0, 0, 0);
        chk("jump_y1", 32'(ypos), 32'd147);
        tick(0, 0, 0, 0, 0, 0, 0);
        chk("jump_y2", 32'(ypos), 32'd133);
        for (int i = 0; i < 13; i++) tick(0, 0, 0, 0, 0, 0, 0);
        chk("jump_peak", 32'(ypos), 32'd42);
        tick(0, 0, 0, 0, 0, 0, 0);
        chk("apex_hold", 32'(ypos), 32'd42);
        tick(0, 0, 0, 0, 0, 0, 0);
        chk("apex_fall", 32'(ypos), 32'd43);

        tick(0, 0, 0, 0, 1, 0, 0);
        y0 = m_y;
        tick(0, 0, 1, 0, 1, 0, 0);
        chk("bonk_jump", 32'(ypos), 32'(y0 - 16));
        tick(0, 0, 0, 1, 0, 0, 0);
        chk("bonk_hold", 32'(ypos), 32'(y0 - 16));
        chk("bonk_air", 32'(on_ground), 32'd0);
        tick(0, 0, 0, 0, 0, 0, 0);
        chk("bonk_desc", 32'(ypos), 32'(y0 - 15));

        tick(0, 0, 0, 0, 1, 0, 0);
        tick(0, 0, 1, 0, 1, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 0);
        do_reset();
        chk("midjump_rst_x", 32'(xpos), 32'd512);
        chk("midjump_rst_y", 32'(ypos), 32'd100);
        tick(0, 0, 0, 0, 0, 0, 0);
        chk("midjump_rst_vy", 32'(ypos), 32'd101);

        for (int i = 0; i < 118; i++) tick(0, 1, 0, 0, 0, 0, 0);
        chk("right_984", 32'(xpos), 32'd984);
        tick(0, 1, 0, 0, 0, 0, 0);
        chk("right_988", 32'(xpos), 32'd988);
        tick(0, 1, 0, 0, 0, 0, 0);
        chk("right_992", 32'(xpos), 32'd992);
        tick(0, 1, 0, 0, 0, 0, 0);
        chk("right_clamp", 32'(xpos), 32'd992);
        tick(0, 1, 0, 0, 0, 0, 1);
        tick(1, 1, 0, 0, 0, 0, 0);
        chk("both_keys", 32'(xpos), 32'd992);
        for (int i = 0; i < 245; i++) tick(1, 0, 0, 0, 0, 0, 0);
        chk("left_clamp", 32'(xpos), 32'd32);
        chk("floor_clamp", 32'(ypos), 32'd736);

`ifdef JUMP_BUFFER_EN
        do_reset();
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 1, 0, 0);
        chk("buf_landed", 32'(on_ground), 32'd1);
        y0 = m_y;
        tick(0, 0, 0, 0, 1, 0, 0);
        chk("buf_jump", 32'(on_ground), 32'd0);
        chk("buf_jump_y", 32'(ypos), 32'(y0 - 16));
        tick(0, 0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 1, 0, 0);
        tick(0, 0, 0, 0, 1, 0, 0);
        chk("buf_expired", 32'(on_ground), 32'd1);
`endif

        do_reset();
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0),
                  1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
